prob4_sweep_ctrl: RTL and testbench

Sequencer that drives the 3-input combinational prob4 function through all 8 input vectors. It uses the fixed order z,x,y (z MSB, y LSB), which matches the existing directed bench ordering. Each vector is held for a programmable settle time, then the result is sampled into an 8-bit truth table and compared against an expected table. This gives the prob4 datapath a self-checking, start/done-handshaked on-chip sweep.

---
 rtl/prob4_sweep_ctrl.sv | 96 +++++++++
 tb/tb_prob4_sweep_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/prob4_sweep_ctrl.sv
// Sweep sequencer for the 3-input prob4 function: walks {z,x,y} = 0..7, holds each
// vector for HOLD_CYCLES, samples the result into a truth table and counts mismatches.
module prob4_sweep_ctrl #(
   parameter int HOLD_CYCLES = 2,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] expected,
   input  logic       dut_out,
   output logic       dut_x,
   output logic       dut_y,
   output logic       dut_z,
   output logic       busy,
   output logic [2:0] vec_idx,
   output logic [7:0] truth_table,
   output logic [3:0] err_count,
   output logic       done,
   output logic       pass
);

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] hold;
   logic [7:0]       exp_q;
   logic             go;
   logic             sample_hit;

   // abort beats start in IDLE, and suppresses a sample that would land on the same edge
   assign go         = (state == IDLE) && start && !abort;
   assign sample_hit = (state == DRIVE) && !abort && (hold == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (go) state_nxt = DRIVE;
         DRIVE: begin
            if (abort)                                state_nxt = IDLE;
            else if (sample_hit && vec_idx == 3'd7)   state_nxt = DONE;
         end
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == DRIVE);
   assign done = (state == DONE);
   assign pass = done && (err_count == 4'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vec_idx                 <= 3'd0;
         hold                    <= '0;
         truth_table             <= 8'h00;
         err_count               <= 4'd0;
         exp_q                   <= 8'h00;
         {dut_z, dut_x, dut_y}   <= 3'd0;
      end else if (go) begin
         vec_idx                 <= 3'd0;
         hold                    <= '0;
         truth_table             <= 8'h00;
         err_count               <= 4'd0;
         exp_q                   <= expected;
         {dut_z, dut_x, dut_y}   <= 3'd0;
      end else if (state == DRIVE) begin
         if (abort) begin
            {dut_z, dut_x, dut_y} <= 3'd0;
         end else if (sample_hit) begin
            truth_table[vec_idx] <= dut_out;
            if (dut_out != exp_q[vec_idx]) err_count <= err_count + 4'd1;
            hold <= '0;
            // the last vector leaves vec_idx at 7 and parks the drive lines low
            if (vec_idx == 3'd7) begin
               {dut_z, dut_x, dut_y} <= 3'd0;
            end else begin
               vec_idx               <= vec_idx + 3'd1;
               {dut_z, dut_x, dut_y} <= vec_idx + 3'd1;
            end
         end else begin
            hold <= hold + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_prob4_sweep_ctrl.sv
// Bench for prob4_sweep_ctrl: two instances (HOLD_CYCLES=2 and 1) driven from a table,
// random sweeps against a truth-table reference model, and hand-written corner sequences.
module tb_prob4_sweep_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start_a, abort_a, start_b, abort_b;
   logic [7:0] exp_a, exp_b, func_a, func_b;
   logic       x_a, y_a, z_a, busy_a, done_a, pass_a;
   logic       x_b, y_b, z_b, busy_b, done_b, pass_b;
   logic [2:0] idx_a, idx_b;
   logic [7:0] tt_a, tt_b;
   logic [3:0] err_a, err_b;
   logic       out_a, out_b;

   // the prob4 stand-in is an arbitrary 3-input function given as a truth table
   assign out_a = func_a[{z_a, x_a, y_a}];
   assign out_b = func_b[{z_b, x_b, y_b}];

   prob4_sweep_ctrl #(.HOLD_CYCLES(2), .CNT_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .expected(exp_a),
      .dut_out(out_a), .dut_x(x_a), .dut_y(y_a), .dut_z(z_a), .busy(busy_a),
      .vec_idx(idx_a), .truth_table(tt_a), .err_count(err_a), .done(done_a), .pass(pass_a));

   prob4_sweep_ctrl #(.HOLD_CYCLES(1), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .expected(exp_b),
      .dut_out(out_b), .dut_x(x_b), .dut_y(y_b), .dut_z(z_b), .busy(busy_b),
      .vec_idx(idx_b), .truth_table(tt_b), .err_count(err_b), .done(done_b), .pass(pass_b));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // reference: mismatches are the positions where function and expected table differ
   function automatic int model_err(input logic [7:0] f, input logic [7:0] e, input int nbits);
      int c = 0;
      for (int i = 0; i < nbits; i++) if (f[i] != e[i]) c++;
      return c;
   endfunction

   function automatic logic [2:0] vec_of(input int sel);
      return (sel == 0) ? {z_a, x_a, y_a} : {z_b, x_b, y_b};
   endfunction

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) start_a = v; else start_b = v;
   endtask

   task automatic sweep(input int sel, input logic [7:0] f, input logic [7:0] e,
                        input logic [7:0] req_tt, input int req_err, input int req_pass,
                        input bit repulse, input string tag);
      int  hold;
      int  lat;
      bit  seen;
      hold = (sel == 0) ? 2 : 1;
      @(negedge clk);
      if (sel == 0) begin func_a = f; exp_a = e; end
      else          begin func_b = f; exp_b = e; end
      set_start(sel, 1'b1);
      @(negedge clk);
      set_start(sel, 1'b0);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 200) begin
         if (lat < 8 * hold) begin
            check({tag, "_vec"}, vec_of(sel), lat / hold);
            check({tag, "_busy"}, (sel == 0) ? busy_a : busy_b, 1);
         end
         set_start(sel, repulse && (lat == 5));
         @(negedge clk);
         lat++;
         seen = (sel == 0) ? done_a : done_b;
      end
      set_start(sel, 1'b0);
      check({tag, "_latency"}, lat, 8 * hold);
      check({tag, "_tt"},   (sel == 0) ? tt_a : tt_b, req_tt);
      check({tag, "_err"},  (sel == 0) ? err_a : err_b, req_err);
      check({tag, "_pass"}, (sel == 0) ? pass_a : pass_b, req_pass);
      check({tag, "_vecout_done"}, vec_of(sel), 0);
      @(negedge clk);
      check({tag, "_done_1cyc"}, (sel == 0) ? done_a : done_b, 0);
      check({tag, "_idx_hold"},  (sel == 0) ? idx_a : idx_b, 7);
      check({tag, "_tt_hold"},   (sel == 0) ? tt_a : tt_b, req_tt);
   endtask

   typedef struct {
      int         sel;
      logic [7:0] func;
      logic [7:0] expv;
      logic [7:0] req_tt;
      int         req_err;
      int         req_pass;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int cnt;
      bit bad;
      logic [7:0] f, e;
      int sel;

      tbl[0] = '{0, 8'hF8, 8'hF8, 8'hF8, 0, 1};   // (x&y)|z
      tbl[1] = '{0, 8'hF8, 8'hF0, 8'hF8, 1, 0};
      tbl[2] = '{1, 8'h96, 8'h96, 8'h96, 0, 1};   // x^y^z
      tbl[3] = '{1, 8'h96, 8'h00, 8'h96, 4, 0};
      tbl[4] = '{0, 8'h00, 8'hFF, 8'h00, 8, 0};   // every vector wrong
      tbl[5] = '{1, 8'hFF, 8'hFF, 8'hFF, 0, 1};

      rst_n = 1'b0;
      start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
      exp_a = 8'h00; exp_b = 8'h00; func_a = 8'hFF; func_b = 8'hFF;
      repeat (3) @(negedge clk);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_pass", pass_a, 0);
      check("rst_vec",  vec_of(0), 0);
      check("rst_idx",  idx_a, 0);
      check("rst_tt",   tt_a, 0);
      check("rst_err",  err_a, 0);
      check("rst_busy_b", busy_b, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++)
         sweep(tbl[i].sel, tbl[i].func, tbl[i].expv, tbl[i].req_tt,
               tbl[i].req_err, tbl[i].req_pass, 1'b0, $sformatf("tbl%0d", i));

      // start re-pulsed mid-sweep must not disturb timing
      sweep(0, 8'hF8, 8'hF8, 8'hF8, 0, 1, 1'b1, "repulse_a");
      sweep(1, 8'h96, 8'h96, 8'h96, 0, 1, 1'b1, "repulse_b");

      for (int i = 0; i < 10; i++) begin
         sel = int'($urandom_range(0, 1));
         f   = 8'($urandom);
         e   = (i % 3 == 0) ? f : 8'($urandom);
         sweep(sel, f, e, f, model_err(f, e, 8), (model_err(f, e, 8) == 0) ? 1 : 0,
               1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      end

      // reset in the middle of a sweep, at vector 4
      @(negedge clk);
      func_a = 8'hF8; exp_a = 8'h00; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      cnt = 0;
      while (idx_a != 3'd4 && cnt < 100) begin @(negedge clk); cnt++; end
      check("midrst_reach_vec4", (cnt < 100) ? 1 : 0, 1);
      check("midrst_tt_before", tt_a, 8'h08);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_busy", busy_a, 0);
      check("midrst_vec",  vec_of(0), 0);
      check("midrst_idx",  idx_a, 0);
      check("midrst_tt",   tt_a, 0);
      check("midrst_err",  err_a, 0);
      check("midrst_done", done_a, 0);

      // abort while vector 3 is being driven
      @(negedge clk);
      func_a = 8'hA5; exp_a = 8'h0F; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      cnt = 0;
      while (idx_a != 3'd3 && cnt < 100) begin @(negedge clk); cnt++; end
      check("abort_reach_vec3", (cnt < 100) ? 1 : 0, 1);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      check("abort_busy", busy_a, 0);
      check("abort_vec",  vec_of(0), 0);
      check("abort_tt",   tt_a, 8'hA5 & 8'h07);
      check("abort_err",  err_a, model_err(8'hA5, 8'h0F, 3));
      bad = 1'b0;
      repeat (30) begin @(negedge clk); if (done_a || busy_a) bad = 1'b1; end
      check("abort_no_done", bad, 0);

      // start and abort together in IDLE: nothing happens
      start_a = 1'b1; abort_a = 1'b1; start_b = 1'b1; abort_b = 1'b1;
      @(negedge clk);
      start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
      check("startabort_busy_a", busy_a, 0);
      check("startabort_busy_b", busy_b, 0);
      bad = 1'b0;
      repeat (20) begin @(negedge clk); if (done_a || busy_a || done_b || busy_b) bad = 1'b1; end
      check("startabort_quiet", bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule
